axi_bram_loader: RTL and testbench
==================================

// Module: axi_bram_loader
// PURPOSE
//  AXI4-Lite slave that drives the processor's shared BRAM port (bram_din/shared_bram_addr/bram_wr_en/bram_dout).
//  The PS uses it to load instruction memory, load and read back data memories, and hold the core in reset.
//  Sits directly upstream of pipelined_processor. Handles one transaction at a time under a small FSM.
// PARAMETERS
//  WIDTH    32    data word width; fixed at 32
//  SIZE     1024  words per BRAM; must match the processor
//  NUM_COL  4     byte lanes (write-strobe width)
//  LOGSIZE  $clog2(SIZE)  localparam; AW = LOGSIZE+4 AXI byte-address bits
// PORTS
//  clk               in   1          clock
//  reset             in   1          asynchronous, active-low
//  s_awaddr          in   AW         write byte address
//  s_awvalid/s_awready in/out 1      AW handshake
//  s_wdata           in   WIDTH      write data
//  s_wstrb           in   NUM_COL    write byte strobes
//  s_wvalid/s_wready in/out 1        W handshake
//  s_bresp           out  2          00 OKAY, 10 SLVERR
//  s_bvalid/s_bready out/in 1        B handshake
//  s_araddr          in   AW         read byte address
//  s_arvalid/s_arready in/out 1      AR handshake
//  s_rdata           out  WIDTH      read data
//  s_rresp           out  2          00 OKAY, 10 SLVERR
//  s_rvalid/s_rready out/in 1        R handshake
//  bram_din          out  WIDTH      write data to processor BRAM port
//  shared_bram_addr  out  LOGSIZE+3  byte address; bit LOGSIZE+2 = 0 instr, 1 data
//  bram_wr_en        out  NUM_COL    byte write enables
//  bram_dout         in   WIDTH      read data; valid 1 cycle after shared_bram_addr is presented
//  cpu_reset         out  1          active-high reset to processor
// BEHAVIOUR
//  Address decode: addr[AW-1] = 0 -> BRAM space, shared_bram_addr = {addr[AW-2:2],2'b00}. addr[AW-1] = 1 -> control space.
//  FSM states: IDLE, WR, WR_RESP, RD_ADDR, RD_WAIT, RD_RESP.
//  IDLE: s_awready = s_wready = (s_awvalid & s_wvalid). AW and W are always accepted together.
//   s_arready = s_arvalid & ~(s_awvalid & s_wvalid). Write wins when both are pending in the same cycle.
//  Write: handshake in cycle N captures addr/data/strb; WR in N+1 drives bram_wr_en = strb for exactly 1 cycle.
//   WR_RESP: bvalid is asserted from N+2 and held until bready; then go to IDLE.
//  Read: handshake in N; RD_ADDR in N+1 drives the address; RD_WAIT in N+2 registers bram_dout into s_rdata.
//   RD_RESP: rvalid is asserted from N+3 and held until rready; then go to IDLE.
//  Outside WR, bram_wr_en = 0. shared_bram_addr and bram_din hold their last values.
//  wstrb = 0: no byte is written, response is OKAY.
//  rdata/resp stay stable while valid && !ready. The next handshake is accepted no earlier than the cycle after the response completes.
//  Reset values: all ready/valid = 0, bresp = rresp = 0, s_rdata = 0, shared_bram_addr = 0, bram_din = 0,
//   bram_wr_en = 0, cpu_reset = 1 (when the macro is defined), state = IDLE.
//  Reset asserted mid-transaction: state returns to IDLE immediately and bram_wr_en drops asynchronously.
//   The in-flight transaction is discarded with no response.
// CONFIGURATION
//  BRIDGE_CTRL_REG_EN defined: control space offset 0x0 holds CTRL, bit0 = cpu_hold, reset value 1; cpu_reset = cpu_hold.
//   A write with wstrb[0] = 1 updates bit0 from wdata[0] in the WR cycle. A read returns {31'b0,cpu_hold}.
//   Other control offsets read 0 and ignore writes. All control-space responses are OKAY. No BRAM access occurs.
//  BRIDGE_CTRL_REG_EN undefined: cpu_reset is tied to 0.
//   Any control-space access returns SLVERR (read data 0), with no BRAM access and the same timing.
// TESTING
//  Write 0xDEADBEEF, strb 1111, to 0x0004 -> in N+1 shared_bram_addr = 0x004, bram_wr_en = 1111; bvalid in N+2 with OKAY.
//  Read 0x0004 with the BRAM model returning 0x12345678 -> rvalid at N+3, rdata 0x12345678, OKAY.
//   Hold rready = 0 for 5 cycles -> rdata stays stable.
//  aw/w/ar all valid in the same cycle -> write completes first, then the read.
//   No overlap: bram_wr_en = 0 during the read.
//  Data-space write 0x0000ABCD, strb 0011, to the byte address with bit LOGSIZE+2 set -> bram_wr_en = 0011 and that address bit = 1.
//  With the macro: after reset cpu_reset = 1; write 0 to the CTRL address -> cpu_reset = 0 from the WR cycle on.
//   Without the macro: the same access returns bresp = 10 and cpu_reset stays 0.
//  Assert reset during WR_RESP (bvalid high) -> bvalid = 0 and bram_wr_en = 0 immediately.
//   After release, a new read completes normally.

Source files
------------

// File: rtl/axi_bram_loader.sv
// AXI4-Lite slave driving the processor's shared BRAM port, one transaction at a time.
// Optional CTRL register (cpu_hold -> cpu_reset) enabled by defining BRIDGE_CTRL_REG_EN.
//
// state   | meaning
// IDLE    | waiting for AW+W or AR handshake
// WR      | byte enables driven for one cycle
// WR_RESP | bvalid held until bready
// RD_ADDR | BRAM address presented
// RD_WAIT | BRAM output captured into s_rdata
// RD_RESP | rvalid held until rready
module axi_bram_loader #(
  parameter int WIDTH   = 32,
  parameter int SIZE    = 1024,
  parameter int NUM_COL = 4,
  localparam int LOGSIZE = $clog2(SIZE),
  localparam int AW      = LOGSIZE + 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [AW-1:0]        s_awaddr,
  input  logic                 s_awvalid,
  output logic                 s_awready,
  input  logic [WIDTH-1:0]     s_wdata,
  input  logic [NUM_COL-1:0]   s_wstrb,
  input  logic                 s_wvalid,
  output logic                 s_wready,
  output logic [1:0]           s_bresp,
  output logic                 s_bvalid,
  input  logic                 s_bready,
  input  logic [AW-1:0]        s_araddr,
  input  logic                 s_arvalid,
  output logic                 s_arready,
  output logic [WIDTH-1:0]     s_rdata,
  output logic [1:0]           s_rresp,
  output logic                 s_rvalid,
  input  logic                 s_rready,
  output logic [WIDTH-1:0]     bram_din,
  output logic [LOGSIZE+2:0]   shared_bram_addr,
  output logic [NUM_COL-1:0]   bram_wr_en,
  input  logic [WIDTH-1:0]     bram_dout,
  output logic                 cpu_reset
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
`ifdef BRIDGE_CTRL_REG_EN
  localparam logic [1:0] RESP_CTRL   = 2'b00;
`else
  localparam logic [1:0] RESP_CTRL   = 2'b10;
`endif

  typedef enum logic [2:0] {IDLE, WR, WR_RESP, RD_ADDR, RD_WAIT, RD_RESP} state_t;

  state_t               state_q, state_d;
  logic                 wr_hs, rd_hs;
  logic                 is_ctrl_q, ctrl_off0_q, wbit0_q;
  logic [NUM_COL-1:0]   strb_q;
  logic [WIDTH-1:0]     ctrl_rdata;

  // Write wins when AW+W and AR arrive together.
  assign wr_hs = (state_q == IDLE) && s_awvalid && s_wvalid;
  assign rd_hs = (state_q == IDLE) && s_arvalid && !(s_awvalid && s_wvalid);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    s_awready  = 1'b0;
    s_wready   = 1'b0;
    s_arready  = 1'b0;
    s_bvalid   = 1'b0;
    s_rvalid   = 1'b0;
    bram_wr_en = '0;
    case (state_q)
      IDLE: begin
        s_awready = wr_hs;
        s_wready  = wr_hs;
        s_arready = rd_hs;
        if (wr_hs)      state_d = WR;
        else if (rd_hs) state_d = RD_ADDR;
      end
      WR: begin
        if (!is_ctrl_q) bram_wr_en = strb_q;
        state_d = WR_RESP;
      end
      WR_RESP: begin
        s_bvalid = 1'b1;
        if (s_bready) state_d = IDLE;
      end
      RD_ADDR: state_d = RD_WAIT;
      RD_WAIT: state_d = RD_RESP;
      RD_RESP: begin
        s_rvalid = 1'b1;
        if (s_rready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      is_ctrl_q        <= 1'b0;
      ctrl_off0_q      <= 1'b0;
      wbit0_q          <= 1'b0;
      strb_q           <= '0;
      s_bresp          <= RESP_OKAY;
      s_rresp          <= RESP_OKAY;
      s_rdata          <= '0;
      bram_din         <= '0;
      shared_bram_addr <= '0;
    end else begin
      if (wr_hs) begin
        is_ctrl_q   <= s_awaddr[AW-1];
        ctrl_off0_q <= (s_awaddr[AW-2:2] == '0);
        wbit0_q     <= s_wdata[0];
        strb_q      <= s_wstrb;
        s_bresp     <= s_awaddr[AW-1] ? RESP_CTRL : RESP_OKAY;
        if (!s_awaddr[AW-1]) begin
          shared_bram_addr <= {s_awaddr[AW-2:2], 2'b00};
          bram_din         <= s_wdata;
        end
      end else if (rd_hs) begin
        is_ctrl_q   <= s_araddr[AW-1];
        ctrl_off0_q <= (s_araddr[AW-2:2] == '0);
        s_rresp     <= s_araddr[AW-1] ? RESP_CTRL : RESP_OKAY;
        if (!s_araddr[AW-1]) shared_bram_addr <= {s_araddr[AW-2:2], 2'b00};
      end
      // BRAM data is valid one cycle after the address was presented in RD_ADDR.
      if (state_q == RD_WAIT) s_rdata <= is_ctrl_q ? ctrl_rdata : bram_dout;
    end
  end

`ifdef BRIDGE_CTRL_REG_EN
  logic cpu_hold;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cpu_hold <= 1'b1;
    else if (state_q == WR && is_ctrl_q && ctrl_off0_q && strb_q[0]) cpu_hold <= wbit0_q;
  end

  assign cpu_reset  = cpu_hold;
  assign ctrl_rdata = ctrl_off0_q ? {{(WIDTH-1){1'b0}}, cpu_hold} : '0;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{s_awaddr[1:0], s_araddr[1:0]};
`else
  assign cpu_reset  = 1'b0;
  assign ctrl_rdata = '0;

  logic unused_ctrl_bits;
  assign unused_ctrl_bits = ^{s_awaddr[1:0], s_araddr[1:0], ctrl_off0_q, wbit0_q};
`endif

endmodule

// File: tb/tb_axi_bram_loader.sv
// Self-checking bench for axi_bram_loader: vector table, response scoreboard and
// hand-written sequences for arbitration and mid-transaction reset.
module tb_axi_bram_loader;
  localparam int WIDTH   = 32;
  localparam int SIZE    = 1024;
  localparam int NUM_COL = 4;
  localparam int LOGSIZE = $clog2(SIZE);
  localparam int AW      = LOGSIZE + 4;

`ifdef BRIDGE_CTRL_REG_EN
  localparam logic [1:0]  CTRL_RESP = 2'b00;
  localparam logic [31:0] CTRL0_RD  = 32'h1;
  localparam logic        RST_CPU   = 1'b1;
`else
  localparam logic [1:0]  CTRL_RESP = 2'b10;
  localparam logic [31:0] CTRL0_RD  = 32'h0;
  localparam logic        RST_CPU   = 1'b0;
`endif

  logic clk = 1'b0, reset = 1'b0;
  logic [AW-1:0] s_awaddr = '0, s_araddr = '0;
  logic s_awvalid = 0, s_wvalid = 0, s_bready = 0, s_arvalid = 0, s_rready = 0;
  logic [WIDTH-1:0] s_wdata = '0;
  logic [NUM_COL-1:0] s_wstrb = '0;
  logic s_awready, s_wready, s_bvalid, s_arready, s_rvalid, cpu_reset;
  logic [1:0] s_bresp, s_rresp;
  logic [WIDTH-1:0] s_rdata, bram_din, bram_dout;
  logic [LOGSIZE+2:0] shared_bram_addr;
  logic [NUM_COL-1:0] bram_wr_en;

  always #5 clk = ~clk;

  axi_bram_loader #(.WIDTH(WIDTH), .SIZE(SIZE), .NUM_COL(NUM_COL)) dut (
    .clk(clk), .reset(reset),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .bram_din(bram_din), .shared_bram_addr(shared_bram_addr), .bram_wr_en(bram_wr_en),
    .bram_dout(bram_dout), .cpu_reset(cpu_reset)
  );

  // BRAM model: instr half then data half, one-cycle registered read, byte-lane writes.
  logic [31:0] mem [0:2*SIZE-1];
  bit mem_ready = 1'b0;
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 2*SIZE; i++) mem[i] <= '0;
      mem[1] <= 32'h12345678;
      mem_ready <= 1'b1;
    end else begin
      bram_dout <= mem[shared_bram_addr[LOGSIZE+2:2]];
      for (int b = 0; b < NUM_COL; b++)
        if (bram_wr_en[b]) mem[shared_bram_addr[LOGSIZE+2:2]][8*b +: 8] <= bram_din[8*b +: 8];
    end
  end

  typedef struct {
    logic        wr;
    logic [AW-1:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
    int          hold;
  } vec_t;
  typedef struct { logic [31:0] data; logic [1:0] resp; } exp_t;

  vec_t vecs [12];
  exp_t sb [$];
  int n_vec = 0, n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic sb_pop(input string name, input logic [31:0] act_data, input logic [1:0] act_resp,
                        input logic is_rd);
    exp_t e;
    if (sb.size() == 0) begin
      n_vec++; n_err++;
      $display("FAIL %s: response with empty scoreboard", name);
      return;
    end
    e = sb.pop_front();
    check({name, "_resp"}, 32'(act_resp), 32'(e.resp));
    if (is_rd) check({name, "_data"}, act_data, e.data);
  endtask

  task automatic do_write(input string name, input logic [AW-1:0] a, input logic [31:0] d,
                          input logic [3:0] s, input logic [1:0] resp);
    int lat;
    exp_t e;
    @(negedge clk);
    s_awaddr = a; s_wdata = d; s_wstrb = s; s_awvalid = 1; s_wvalid = 1;
    #1;
    check({name, "_awready"}, 32'(s_awready), 32'h1);
    check({name, "_wready"}, 32'(s_wready), 32'h1);
    e.data = '0; e.resp = resp; sb.push_back(e);
    @(negedge clk);
    s_awvalid = 0; s_wvalid = 0;
    check({name, "_wr_en"}, 32'(bram_wr_en), a[AW-1] ? 32'h0 : 32'(s));
    if (!a[AW-1]) check({name, "_addr"}, 32'(shared_bram_addr), 32'({a[AW-2:2], 2'b00}));
    lat = 1;
    while (!s_bvalid && lat < 20) begin @(negedge clk); lat++; end
    check({name, "_b_latency"}, 32'(lat), 32'd2);
    if (s_bvalid) begin
      check({name, "_wr_en_off"}, 32'(bram_wr_en), 32'h0);
      sb_pop(name, '0, s_bresp, 1'b0);
      s_bready = 1;
      @(negedge clk);
      s_bready = 0;
      check({name, "_bvalid_drop"}, 32'(s_bvalid), 32'h0);
    end else e = sb.pop_back();
  endtask

  task automatic do_read(input string name, input logic [AW-1:0] a, input logic [31:0] d,
                         input logic [1:0] resp, input int hold);
    int lat;
    exp_t e;
    logic [31:0] rd0;
    @(negedge clk);
    s_araddr = a; s_arvalid = 1;
    #1;
    check({name, "_arready"}, 32'(s_arready), 32'h1);
    e.data = d; e.resp = resp; sb.push_back(e);
    @(negedge clk);
    s_arvalid = 0;
    if (!a[AW-1]) check({name, "_addr"}, 32'(shared_bram_addr), 32'({a[AW-2:2], 2'b00}));
    lat = 1;
    while (!s_rvalid && lat < 20) begin @(negedge clk); lat++; end
    check({name, "_r_latency"}, 32'(lat), 32'd3);
    if (s_rvalid) begin
      rd0 = s_rdata;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        check({name, "_hold_valid"}, 32'(s_rvalid), 32'h1);
        check({name, "_hold_data"}, s_rdata, rd0);
      end
      sb_pop(name, s_rdata, s_rresp, 1'b1);
      s_rready = 1;
      @(negedge clk);
      s_rready = 0;
      check({name, "_rvalid_drop"}, 32'(s_rvalid), 32'h0);
    end else e = sb.pop_back();
  endtask

  initial begin
    int lat;
    exp_t e;

    vecs[0]  = '{1'b0, 14'h0004, 32'h0,        4'h0, 32'h12345678, 2'b00, 5};
    vecs[1]  = '{1'b1, 14'h0004, 32'hDEADBEEF, 4'hF, 32'h0,        2'b00, 0};
    vecs[2]  = '{1'b0, 14'h0004, 32'h0,        4'h0, 32'hDEADBEEF, 2'b00, 0};
    vecs[3]  = '{1'b1, 14'h1008, 32'h0000ABCD, 4'h3, 32'h0,        2'b00, 0};
    vecs[4]  = '{1'b0, 14'h1008, 32'h0,        4'h0, 32'h0000ABCD, 2'b00, 0};
    vecs[5]  = '{1'b1, 14'h0004, 32'hFFFFFFFF, 4'h0, 32'h0,        2'b00, 0};
    vecs[6]  = '{1'b0, 14'h0004, 32'h0,        4'h0, 32'hDEADBEEF, 2'b00, 0};
    vecs[7]  = '{1'b1, 14'h0004, 32'h00AA0000, 4'h4, 32'h0,        2'b00, 0};
    vecs[8]  = '{1'b0, 14'h0004, 32'h0,        4'h0, 32'hDEAABEEF, 2'b00, 0};
    vecs[9]  = '{1'b0, 14'h0008, 32'h0,        4'h0, 32'h0,        2'b00, 0};
    vecs[10] = '{1'b0, 14'h2004, 32'h0,        4'h0, 32'h0,        CTRL_RESP, 0};
    vecs[11] = '{1'b0, 14'h2000, 32'h0,        4'h0, CTRL0_RD,     CTRL_RESP, 0};

    repeat (3) @(negedge clk);
    check("rst_awready", 32'(s_awready), 32'h0);
    check("rst_arready", 32'(s_arready), 32'h0);
    check("rst_bvalid", 32'(s_bvalid), 32'h0);
    check("rst_rvalid", 32'(s_rvalid), 32'h0);
    check("rst_resp", 32'({s_bresp, s_rresp}), 32'h0);
    check("rst_rdata", s_rdata, 32'h0);
    check("rst_addr", 32'(shared_bram_addr), 32'h0);
    check("rst_din", bram_din, 32'h0);
    check("rst_wr_en", 32'(bram_wr_en), 32'h0);
    check("rst_cpu_reset", 32'(cpu_reset), 32'(RST_CPU));
    reset = 1;
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      if (vecs[i].wr) do_write($sformatf("vec%0d", i), vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].exp_resp);
      else do_read($sformatf("vec%0d", i), vecs[i].addr, vecs[i].exp_data, vecs[i].exp_resp, vecs[i].hold);
    end

    // CTRL write of 0 releases the core (or is rejected without the register).
    check("ctrl_cpu_reset_before", 32'(cpu_reset), 32'(RST_CPU));
    do_write("ctrl_wr", 14'h2000, 32'h0, 4'h1, CTRL_RESP);
    check("ctrl_cpu_reset_after", 32'(cpu_reset), 32'h0);
    do_read("ctrl_rd_after", 14'h2000, 32'h0, CTRL_RESP, 0);

    // AW/W and AR together: write first, then read, no write enables during the read.
    @(negedge clk);
    s_awaddr = 14'h000C; s_wdata = 32'hCAFEF00D; s_wstrb = 4'hF; s_awvalid = 1; s_wvalid = 1;
    s_araddr = 14'h000C; s_arvalid = 1;
    #1;
    check("both_awready", 32'(s_awready), 32'h1);
    check("both_arready_blocked", 32'(s_arready), 32'h0);
    e.data = '0; e.resp = 2'b00; sb.push_back(e);
    e.data = 32'hCAFEF00D; e.resp = 2'b00; sb.push_back(e);
    @(negedge clk);
    s_awvalid = 0; s_wvalid = 0;
    check("both_wr_en", 32'(bram_wr_en), 32'hF);
    lat = 1;
    while (!s_bvalid && lat < 20) begin @(negedge clk); lat++; end
    check("both_b_latency", 32'(lat), 32'd2);
    check("both_arready_wr_resp", 32'(s_arready), 32'h0);
    sb_pop("both_wr", '0, s_bresp, 1'b0);
    s_bready = 1;
    @(negedge clk);
    s_bready = 0;
    check("both_arready_idle", 32'(s_arready), 32'h1);
    @(negedge clk);
    s_arvalid = 0;
    lat = 1;
    check("both_rd_wr_en", 32'(bram_wr_en), 32'h0);
    while (!s_rvalid && lat < 20) begin
      @(negedge clk); lat++;
      check("both_rd_wr_en", 32'(bram_wr_en), 32'h0);
    end
    check("both_r_latency", 32'(lat), 32'd3);
    sb_pop("both_rd", s_rdata, s_rresp, 1'b1);
    s_rready = 1;
    @(negedge clk);
    s_rready = 0;

    // Reset while bvalid is high: response discarded, write already landed.
    @(negedge clk);
    s_awaddr = 14'h0010; s_wdata = 32'h55AA55AA; s_wstrb = 4'hF; s_awvalid = 1; s_wvalid = 1;
    e.data = '0; e.resp = 2'b00; sb.push_back(e);
    @(negedge clk);
    s_awvalid = 0; s_wvalid = 0;
    lat = 1;
    while (!s_bvalid && lat < 20) begin @(negedge clk); lat++; end
    check("rstb_bvalid_seen", 32'(s_bvalid), 32'h1);
    #1 reset = 0;
    #1;
    check("rstb_bvalid", 32'(s_bvalid), 32'h0);
    check("rstb_wr_en", 32'(bram_wr_en), 32'h0);
    check("rstb_cpu_reset", 32'(cpu_reset), 32'(RST_CPU));
    sb.delete();
    @(negedge clk);
    reset = 1;

    // Reset during the WR cycle: byte enables drop before the write edge.
    @(negedge clk);
    s_awaddr = 14'h0014; s_wdata = 32'h11111111; s_wstrb = 4'hF; s_awvalid = 1; s_wvalid = 1;
    @(negedge clk);
    s_awvalid = 0; s_wvalid = 0;
    check("rstw_wr_en_high", 32'(bram_wr_en), 32'hF);
    #1 reset = 0;
    #1;
    check("rstw_wr_en_async", 32'(bram_wr_en), 32'h0);
    @(negedge clk);
    reset = 1;

    do_read("post_rst_rd", 14'h0010, 32'h55AA55AA, 2'b00, 0);
    do_read("aborted_wr_rd", 14'h0014, 32'h0, 2'b00, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", n_vec, n_err);
    $fatal(1);
  end

endmodule
